param_updown_counter: RTL and testbench

- Parametrised successor to the 8-bit up/down counter: configurable width and modulus, variable step, synchronous load, and three boundary modes (wrap, saturate, one-shot).
- Provides registered terminal-count, overflow and done flags.
- Used as the general-purpose event/timer counter in the exercise designs, driven directly by the top level or a controlling FSM.

---
 rtl/param_updown_counter.sv | 148 ++++++++++++++
 tb/tb_param_updown_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with variable step, synchronous load, and
// wrap / saturate / one-shot boundary handling. tc, ovf_sticky and done are
// registered. at_max and at_min decode counter_out combinationally.
module param_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              direction,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  counter_out,
    output logic              tc,
    output logic              ovf_sticky,
    output logic              done,
    output logic              at_max,
    output logic              at_min
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_SAT_ALT  = 2'b11
    } mode_e;

    // Illegal parameter combinations stop elaboration.
    if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
        $error("param_updown_counter: MAX_COUNT out of range");
    end
    if (2**STEP_W - 1 > MAX_COUNT) begin : g_bad_step
        $error("param_updown_counter: STEP_W too wide for MAX_COUNT");
    end
    if (RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_rst
        $error("param_updown_counter: RESET_VAL out of range");
    end

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_COUNT + 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    mode_e            mode_s;
    logic             oneshot;
    logic             wrap_mode;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_wrap;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] diff_wrap;
    logic             under;
    logic [WIDTH-1:0] load_clamped;
    logic             ovf_set;

    // Decode mode and compute WIDTH+1-bit raw results for both directions.
    always_comb begin
        mode_s       = mode_e'(mode);
        oneshot      = (mode_s == MODE_ONESHOT);
        wrap_mode    = (mode_s == MODE_WRAP);
        cnt_ext      = {1'b0, cnt_q};
        step_ext     = (WIDTH+1)'(step);
        sum          = cnt_ext + step_ext;
        sum_wrap     = WIDTH'(sum - MOD_EXT);
        under        = (cnt_ext < step_ext);
        diff         = WIDTH'(cnt_ext - step_ext);
        diff_wrap    = WIDTH'(cnt_ext + MOD_EXT - step_ext);
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    end

    // Next-state selection: load beats enable; rst is applied in the register.
    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        done_d  = oneshot ? done_q : 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            cnt_d  = load_clamped;
            done_d = 1'b0;
        end else if (enable && (step != '0) && !(oneshot && done_q)) begin
            if (direction) begin
                if (sum > MAX_EXT) begin
                    ovf_set = 1'b1;
                    tc_d    = 1'b1;
                    cnt_d   = wrap_mode ? sum_wrap : MAX_W;
                end else begin
                    cnt_d = WIDTH'(sum);
                    tc_d  = (sum == MAX_EXT);
                end
                if (oneshot && (cnt_d == MAX_W)) begin
                    done_d = 1'b1;
                end
            end else begin
                if (under) begin
                    ovf_set = 1'b1;
                    tc_d    = 1'b1;
                    cnt_d   = wrap_mode ? diff_wrap : '0;
                end else begin
                    cnt_d = diff;
                    tc_d  = (diff == '0);
                end
                if (oneshot && (cnt_d == '0)) begin
                    done_d = 1'b1;
                end
            end
        end
        // A new over/underflow outranks a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RST_W;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    // Outputs: registered state plus combinational bound decodes.
    always_comb begin
        counter_out = cnt_q;
        tc          = tc_q;
        ovf_sticky  = ovf_q;
        done        = done_q;
        at_max      = (cnt_q == MAX_W);
        at_min      = (cnt_q == '0);
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=8, MAX_COUNT=199, RESET_VAL=5).
module tb_param_updown_counter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       direction;
    logic [3:0] step;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic       clr_flags;
    logic [7:0] counter_out;
    logic       tc;
    logic       ovf_sticky;
    logic       done;
    logic       at_max;
    logic       at_min;

    int checks;
    int errors;

    param_updown_counter #(
        .WIDTH(8),
        .MAX_COUNT(199),
        .STEP_W(4),
        .RESET_VAL(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .direction(direction),
        .step(step),
        .mode(mode),
        .load(load),
        .load_val(load_val),
        .clr_flags(clr_flags),
        .counter_out(counter_out),
        .tc(tc),
        .ovf_sticky(ovf_sticky),
        .done(done),
        .at_max(at_max),
        .at_min(at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; enable = 1'b0; direction = 1'b1; step = 4'd0;
        mode = 2'b00; load = 1'b0; load_val = 8'd0; clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; enable = 1'b1; step = 4'd3;
        tick(); tick();
        checks++; if (counter_out !== 8'd5) begin errors++; $display("FAIL reset_cnt got %0d exp 5", counter_out); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b exp 0", tc); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_sticky); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (at_min !== 1'b0 || at_max !== 1'b0) begin errors++; $display("FAIL reset_bounds got %b%b exp 00", at_max, at_min); end
        rst = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (counter_out !== 8'd5 || tc !== 1'b0) begin errors++; $display("FAIL hold_%0d got cnt %0d tc %b exp 5 0", i, counter_out, tc); end
        end
    endtask

    task automatic test_wrap();
        idle();
        load = 1'b1; load_val = 8'd197;
        tick();
        checks++; if (counter_out !== 8'd197) begin errors++; $display("FAIL wrap_load got %0d exp 197", counter_out); end
        load = 1'b0; enable = 1'b1; direction = 1'b1; step = 4'd3;
        tick();
        checks++; if (counter_out !== 8'd0) begin errors++; $display("FAIL wrap_up_cnt got %0d exp 0", counter_out); end
        checks++; if (tc !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL wrap_up_flags got tc %b ovf %b exp 1 1", tc, ovf_sticky); end
        checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL wrap_at_min got %b exp 1", at_min); end
        direction = 1'b0; step = 4'd2;
        tick();
        checks++; if (counter_out !== 8'd198) begin errors++; $display("FAIL wrap_down_cnt got %0d exp 198", counter_out); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL wrap_down_tc got %b exp 1", tc); end
        enable = 1'b0; clr_flags = 1'b1;
        tick();
        checks++; if (ovf_sticky !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL wrap_clr got ovf %b tc %b exp 0 0", ovf_sticky, tc); end
    endtask

    task automatic test_saturate();
        idle();
        mode = 2'b01; load = 1'b1; load_val = 8'd2;
        tick();
        load = 1'b0; enable = 1'b1; direction = 1'b0; step = 4'd5;
        tick();
        checks++; if (counter_out !== 8'd0 || tc !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_down got cnt %0d tc %b ovf %b exp 0 1 1", counter_out, tc, ovf_sticky); end
        tick();
        checks++; if (counter_out !== 8'd0 || tc !== 1'b1) begin errors++; $display("FAIL sat_pinned got cnt %0d tc %b exp 0 1", counter_out, tc); end
        enable = 1'b0;
        tick();
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL sat_tc_drop got %b exp 0", tc); end
        clr_flags = 1'b1; load = 1'b1; load_val = 8'd194;
        tick();
        checks++; if (counter_out !== 8'd194 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_load got cnt %0d ovf %b exp 194 0", counter_out, ovf_sticky); end
        clr_flags = 1'b0; load = 1'b0; enable = 1'b1; direction = 1'b1; step = 4'd5;
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b1 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_exact got cnt %0d tc %b ovf %b exp 199 1 0", counter_out, tc, ovf_sticky); end
        checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL sat_at_max got %b exp 1", at_max); end
        mode = 2'b11;
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_mode3 got cnt %0d tc %b ovf %b exp 199 1 1", counter_out, tc, ovf_sticky); end
    endtask

    task automatic test_oneshot();
        idle();
        clr_flags = 1'b1; mode = 2'b10; load = 1'b1; load_val = 8'd190;
        tick();
        checks++; if (counter_out !== 8'd190 || done !== 1'b0) begin errors++; $display("FAIL os_load got cnt %0d done %b exp 190 0", counter_out, done); end
        clr_flags = 1'b0; load = 1'b0; enable = 1'b1; direction = 1'b1; step = 4'd3;
        tick();
        checks++; if (counter_out !== 8'd193 || tc !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL os_193 got cnt %0d tc %b done %b exp 193 0 0", counter_out, tc, done); end
        tick();
        checks++; if (counter_out !== 8'd196 || done !== 1'b0) begin errors++; $display("FAIL os_196 got cnt %0d done %b exp 196 0", counter_out, done); end
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL os_199 got cnt %0d tc %b done %b exp 199 1 1", counter_out, tc, done); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL os_ovf got %b exp 0", ovf_sticky); end
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL os_hold got cnt %0d tc %b done %b exp 199 0 1", counter_out, tc, done); end
        direction = 1'b0;
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b0) begin errors++; $display("FAIL os_blocked got cnt %0d tc %b exp 199 0", counter_out, tc); end
        load = 1'b1; load_val = 8'd10;
        tick();
        checks++; if (counter_out !== 8'd10 || done !== 1'b0) begin errors++; $display("FAIL os_reload got cnt %0d done %b exp 10 0", counter_out, done); end
        load = 1'b0; direction = 1'b1;
        tick();
        checks++; if (counter_out !== 8'd13) begin errors++; $display("FAIL os_resume got %0d exp 13", counter_out); end
        load = 1'b1; load_val = 8'd196;
        tick();
        load = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL os_done2 got %b exp 1", done); end
        enable = 1'b0; mode = 2'b00;
        tick();
        checks++; if (done !== 1'b0 || counter_out !== 8'd199) begin errors++; $display("FAIL os_leave got done %b cnt %0d exp 0 199", done, counter_out); end
    endtask

    task automatic test_priority();
        idle();
        rst = 1'b1; load = 1'b1; load_val = 8'd50; enable = 1'b1; step = 4'd3;
        tick();
        checks++; if (counter_out !== 8'd5) begin errors++; $display("FAIL prio_rst got %0d exp 5", counter_out); end
        rst = 1'b0;
        tick();
        checks++; if (counter_out !== 8'd50) begin errors++; $display("FAIL prio_load got %0d exp 50", counter_out); end
        load_val = 8'd250;
        tick();
        checks++; if (counter_out !== 8'd199 || at_max !== 1'b1) begin errors++; $display("FAIL load_clamp got cnt %0d at_max %b exp 199 1", counter_out, at_max); end
        load = 1'b0; step = 4'd0;
        tick();
        checks++; if (counter_out !== 8'd199 || tc !== 1'b0) begin errors++; $display("FAIL step0 got cnt %0d tc %b exp 199 0", counter_out, tc); end
    endtask

    task automatic test_flag_race();
        idle();
        clr_flags = 1'b1; enable = 1'b1; direction = 1'b1; step = 4'd1;
        tick();
        checks++; if (counter_out !== 8'd0 || tc !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL race got cnt %0d tc %b ovf %b exp 0 1 1", counter_out, tc, ovf_sticky); end
        enable = 1'b0;
        tick();
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL race_clr got %b exp 0", ovf_sticky); end
    endtask

    task automatic test_random();
        int m;
        logic en_r;
        logic dir_r;
        int st;
        idle();
        load = 1'b1; load_val = 8'd100;
        tick();
        load = 1'b0;
        m = 100;
        for (int i = 0; i < 20; i++) begin
            en_r  = 1'($urandom_range(0, 1));
            dir_r = 1'($urandom_range(0, 1));
            st    = int'($urandom_range(0, 15));
            enable = en_r; direction = dir_r; step = 4'(st);
            tick();
            if (en_r && st != 0) m = dir_r ? (m + st) % 200 : (m - st + 200) % 200;
            checks++; if (counter_out !== 8'(m)) begin errors++; $display("FAIL rand_%0d got %0d exp %0d", i, counter_out, m); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle();
        test_reset();
        test_wrap();
        test_saturate();
        test_oneshot();
        test_priority();
        test_flag_race();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
